// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int LATENCY_DEF = 4;
  localparam int DEPTH_DEF   = 256;
  localparam int CNT_W       = 4;
endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with synchronous write and registered read.
// Only the read-data register is reset; the storage itself keeps its contents.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read data holds its value until the next load
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= 32'd0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: fixed-latency load/store with one-cycle ack.
// Optional misaligned-access checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic             mis_q;
  logic             busy_q;
  logic             ack_q;
  logic             err_q;

  logic             mis_in;
  logic             accept;
  logic             fire;
  logic             from_inputs;
  logic             mem_we;
  logic             mem_mis;
  logic [AW-1:0]    mem_idx;
  logic [31:0]      mem_wdata;
  logic             unused_addr;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_in = (addr_i[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif
  assign unused_addr = &{addr_i[31:AW+2], addr_i[1:0]};

  // The array access happens on the edge that enters RESP; with LATENCY=1 that
  // is the accept edge itself, so the live inputs feed the array directly.
  assign accept      = (state_q == IDLE) && req_i;
  assign fire        = rst_i && (((state_q == ACCESS) && (cnt_q <= CNT_W'(1))) ||
                                 (accept && (LATENCY == 1)));
  assign from_inputs = (state_q == IDLE);
  assign mem_we      = from_inputs ? we_i : we_q;
  assign mem_mis     = from_inputs ? mis_in : mis_q;
  assign mem_idx     = from_inputs ? addr_i[AW+1:2] : idx_q;
  assign mem_wdata   = from_inputs ? wdata_i : wdata_q;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (fire && !mem_mis),
    .we_i    (mem_we),
    .addr_i  (mem_idx),
    .wdata_i (mem_wdata),
    .rdata_o (rdata_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= wdata_i;
            mis_q   <= mis_in;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            if (LATENCY == 1) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
              err_q   <= mis_in;
            end else begin
              state_q <= ACCESS;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= RESP;
            ack_q   <= 1'b1;
            err_q   <= mis_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=4, DEPTH=256).
module tb_dmem_responder;
  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_responder #(.LATENCY(LAT), .DEPTH(256)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .busy_o  (busy),
    .ack_o   (ack),
    .rdata_o (rdata),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access; the ack cycle ends at edge accept+LAT, so it is seen
  // LAT-1 samples after the accept edge.
  task automatic do_access(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic scramble,
                           output logic [31:0] rd, output logic er);
    int n;
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    check_eq({tag, ".busy"}, {31'd0, busy}, 32'd1);
    if (scramble) begin
      we = ~w; addr = a + 32'd4; wdata = ~d;
    end
    n = 0;
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, ".lat"}, n, LAT - 1);
    rd = rdata;
    er = err;
    req = 1'b0;
    tick();
    check_eq({tag, ".ackpulse"}, {31'd0, ack}, 32'd0);
    check_eq({tag, ".idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          acks;
    int          ack_cyc [2];
    int          n;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    tick();
    tick();
    rst_n = 1'b1;
    check_eq("rst.busy", {31'd0, busy}, 32'd0);
    check_eq("rst.ack", {31'd0, ack}, 32'd0);
    check_eq("rst.rdata", rdata, 32'd0);
    check_eq("rst.err", {31'd0, err}, 32'd0);

    do_access("st10", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er);
    check_eq("st10.err", {31'd0, er}, 32'd0);
    do_access("ld10", 1'b0, 32'h10, 32'd0, 1'b0, rd, er);
    check_eq("ld10.data", rd, 32'hDEADBEEF);

    tick();
    tick();
    do_access("st30", 1'b1, 32'h30, 32'h0BADF00D, 1'b0, rd, er);
    check_eq("hold.rdata", rdata, 32'hDEADBEEF);

    do_access("st400", 1'b1, 32'h400, 32'h12345678, 1'b0, rd, er);
    do_access("ld000", 1'b0, 32'h000, 32'd0, 1'b0, rd, er);
    check_eq("wrap.data", rd, 32'h12345678);

    // Inputs changed mid-access must not affect the captured store
    do_access("st50", 1'b1, 32'h50, 32'h01020304, 1'b1, rd, er);
    do_access("ld50", 1'b0, 32'h50, 32'd0, 1'b0, rd, er);
    check_eq("ignore.data", rd, 32'h01020304);

    // Reset in the second ACCESS cycle aborts the store
    do_access("st20", 1'b1, 32'h20, 32'h11112222, 1'b0, rd, er);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555;
    tick();
    tick();
    rst_n = 1'b0; req = 1'b0;
    acks = 0;
    tick();
    check_eq("abort.busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (ack) acks++;
      tick();
    end
    check_eq("abort.noack", acks, 0);
    do_access("ld20", 1'b0, 32'h20, 32'd0, 1'b0, rd, er);
    check_eq("abort.data", rd, 32'h11112222);

    // Held request: pulses in cycles 4 and 9 counting the accept edge as 0
    req = 1'b1; we = 1'b0; addr = 32'h10;
    acks = 0;
    ack_cyc[0] = -1; ack_cyc[1] = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack) begin
        if (acks < 2) ack_cyc[acks] = i + 1;
        acks++;
      end
    end
    req = 1'b0;
    check_eq("held.count", acks, 2);
    check_eq("held.ack0", ack_cyc[0], 4);
    check_eq("held.ack1", ack_cyc[1], 9);
    check_eq("held.data", rdata, 32'hDEADBEEF);
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check_eq("held.drain", {31'd0, busy}, 32'd0);

    do_access("st44", 1'b1, 32'h44, 32'hCAFEF00D, 1'b0, rd, er);
    do_access("ld44", 1'b0, 32'h44, 32'd0, 1'b0, rd, er);
    check_eq("raw.data", rd, 32'hCAFEF00D);

    do_access("st22", 1'b1, 32'h22, 32'h55667788, 1'b0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    check_eq("mis.err", {31'd0, er}, 32'd1);
    do_access("ld20b", 1'b0, 32'h20, 32'd0, 1'b0, rd, er);
    check_eq("mis.data", rd, 32'h11112222);
`else
    check_eq("mis.err", {31'd0, er}, 32'd0);
    do_access("ld20b", 1'b0, 32'h20, 32'd0, 1'b0, rd, er);
    check_eq("mis.data", rd, 32'h55667788);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to ack_o (legal range 1..15).
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored (power of two).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_i  input  1  MEM-stage access request, held high by the requester until ack_o.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load; sampled with req_i.
REQ-007 SHALL have port addr_i  input  32  byte address; word index = addr_i[log2(DEPTH)+1:2].
REQ-008 SHALL have port wdata_i  input  32  store data; sampled with req_i.
REQ-009 SHALL have port busy_o  output  1  high while an accepted access is in progress.
REQ-010 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata_o  output  32  load data, valid in the ack_o cycle of a load.
REQ-012 SHALL have port err_o  output  1  misaligned-access flag, valid in the ack_o cycle.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-014 In IDLE with req_i=1 at edge k, SHALL capture we_i/addr_i/wdata_i, set busy_o=1 and enter ACCESS with countdown loaded to LATENCY-1.
REQ-015 In ACCESS, SHALL decrement the countdown each cycle and enter RESP when it reaches 0; LATENCY=1 goes directly to RESP.
REQ-016 On entering RESP, SHALL perform the access: a store writes the captured word; a load drives rdata_o with the stored word.
REQ-017 SHALL assert ack_o=1 for exactly one cycle, the RESP cycle, which is cycle k+LATENCY; busy_o SHALL stay 1 through that cycle.
REQ-018 RESP SHALL always return to IDLE; a req_i still high in the RESP cycle SHALL NOT be accepted until IDLE.
REQ-019 Back-to-back throughput SHALL be one access per LATENCY+1 cycles.
REQ-020 Changes on req_i/addr_i/we_i/wdata_i while busy_o=1 SHALL be ignored.
REQ-021 rdata_o SHALL hold its last load value across stores and idle cycles.
REQ-022 Address bits above the word index SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-023 A store immediately followed by a load to the same word SHALL return the new data.

Reset
REQ-024 With rst_i=0 at an edge: state=IDLE, busy_o=0, ack_o=0, rdata_o=0, err_o=0, countdown=0.
REQ-025 Reset during ACCESS SHALL abort the access with no write and no ack_o.
REQ-026 Storage array contents SHALL NOT be reset.

Configuration
REQ-027 Macro DMEM_MISALIGN_CHECK_EN defined: addr_i[1:0]!=0 SHALL set err_o=1 in the ack_o cycle, suppress the write, and leave rdata_o unchanged.
REQ-028 Macro DMEM_MISALIGN_CHECK_EN undefined: err_o SHALL be tied 0 and addr_i[1:0] ignored.

Structure
REQ-029 Package dmem_pkg SHALL hold the FSM state enum, default LATENCY/DEPTH constants and the countdown width (4 bits).
REQ-030 Storage SHALL be a sub-module dmem_array: synchronous write and read, with one read/write port.

Verification
REQ-031 Reset: rst_i=0 for 2 cycles, then 1 -> all outputs 0 and state IDLE.
REQ-032 Store then load: store 0xDEADBEEF to 0x10 -> ack_o at k+4; then load 0x10 -> rdata_o=0xDEADBEEF at ack_o.
REQ-033 Wrap: DEPTH=256, store 0x12345678 to 0x400, then load 0x000 -> 0x12345678.
REQ-034 Reset mid-access: store 0xAAAA5555 to 0x20, rst_i=0 in the second ACCESS cycle, then load 0x20 -> prior contents, no ack_o for the aborted store.
REQ-035 Held request: req_i held high for 12 cycles with LATENCY=4 -> exactly two ack_o pulses, at cycles 4 and 9.
REQ-036 Misaligned (macro defined): store to 0x22 -> err_o=1 with ack_o and word 0x20 unchanged; macro undefined -> err_o=0 and word 0x20 written.
